// File: rtl/rst_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : rst_sequencer
// Purpose  : Switch reset sequencer. It synchronizes the deassertion of the
//            asynchronous reset, holds the core in reset for a stretch
//            period, and then releases the per-port resets one at a time.
//            Once the sequence is complete, a rising edge on soft_rst_req
//            restarts the sequence from the stretch phase.
// Ports    : clk          - single clock for all logic
//            rst_n        - asynchronous active-low reset
//            soft_rst_req - soft reset request (rising-edge triggered)
//            soft_rst_ack - one-cycle pulse when a soft reset is accepted
//            core_rst_n   - active-low switch core reset
//            port_rst_n   - active-low per-port resets [NUM_PORTS-1:0]
//            rst_done     - high once the full release sequence is complete
//            rst_evt_cnt  - saturating soft-reset event count [7:0]
//                           (present only with RST_SEQ_EVT_CNT_EN defined)
// Options  : RST_SEQ_EVT_CNT_EN - adds the rst_evt_cnt output and its counter
// Revision : 1.0 - initial release
// ============================================================================
module rst_sequencer #(
    parameter int SYNC_STAGES = 2,
    parameter int STRETCH     = 16,
    parameter int NUM_PORTS   = 4,
    parameter int STAGE_GAP   = 4
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 soft_rst_req,
    output logic                 soft_rst_ack,
    output logic                 core_rst_n,
    output logic [NUM_PORTS-1:0] port_rst_n,
    output logic                 rst_done
`ifdef RST_SEQ_EVT_CNT_EN
    ,
    output logic [7:0]           rst_evt_cnt
`endif
);

    localparam int REL_SPAN = STAGE_GAP * NUM_PORTS;
    localparam int CNT_MAX  = (STRETCH > REL_SPAN) ? STRETCH : REL_SPAN;
    localparam int CNT_W    = $clog2(CNT_MAX) + 1;

    typedef enum logic [2:0] {
        ST_ASSERT  = 3'd0,
        ST_SYNC    = 3'd1,
        ST_STRETCH = 3'd2,
        ST_RELEASE = 3'd3,
        ST_RUN     = 3'd4
    } state_t;

    state_t                 state_q, state_d;
    logic [SYNC_STAGES-1:0] sync_q, sync_d;
    logic [CNT_W-1:0]       cnt_q, cnt_d;
    logic                   core_q, core_d;
    logic [NUM_PORTS-1:0]   port_q, port_d;
    logic                   done_q, done_d;
    logic                   ack_q, ack_d;
    logic                   req_prev_q, req_prev_d;
    logic                   w_rise;

    assign w_rise = soft_rst_req & ~req_prev_q;

    always_comb begin
        state_d    = state_q;
        // Only ones are ever shifted in, so OR-ing the old value keeps the
        // chain identical to a plain shifter while reading every stage.
        sync_d     = {sync_q[SYNC_STAGES-2:0], 1'b1} | sync_q;
        cnt_d      = cnt_q;
        core_d     = core_q;
        port_d     = port_q;
        done_d     = done_q;
        ack_d      = 1'b0;
        // The previous sample tracks the request in every state, so an edge
        // seen outside RUN is consumed rather than remembered.
        req_prev_d = soft_rst_req;

        case (state_q)
            ST_ASSERT, ST_SYNC: begin
                state_d = ST_SYNC;
                // Leave as soon as the freshly shifted chain shows a 1 in its
                // last stage; the counter starts counting on the next edge.
                if (sync_d[SYNC_STAGES-1]) begin
                    state_d = ST_STRETCH;
                    cnt_d   = CNT_W'(STRETCH);
                end
            end
            ST_STRETCH: begin
                if (cnt_q <= CNT_W'(1)) begin
                    cnt_d   = '0;
                    core_d  = 1'b1;
                    state_d = ST_RELEASE;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            ST_RELEASE: begin
                // Count up from the core release; saturate at the final
                // port release point so the counter never wraps.
                if (cnt_q < CNT_W'(REL_SPAN)) begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
                for (int i = 0; i < NUM_PORTS; i++) begin
                    if (cnt_d == CNT_W'(STAGE_GAP * (i + 1))) begin
                        port_d[i] = 1'b1;
                    end
                end
                if (port_q[NUM_PORTS-1]) begin
                    done_d  = 1'b1;
                    state_d = ST_RUN;
                end
            end
            ST_RUN: begin
                if (w_rise) begin
                    core_d  = 1'b0;
                    port_d  = '0;
                    done_d  = 1'b0;
                    ack_d   = 1'b1;
                    cnt_d   = CNT_W'(STRETCH);
                    state_d = ST_STRETCH;
                end
            end
            default: begin
                state_d = ST_ASSERT;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_ASSERT;
            sync_q     <= '0;
            cnt_q      <= '0;
            core_q     <= 1'b0;
            port_q     <= '0;
            done_q     <= 1'b0;
            ack_q      <= 1'b0;
            // Reset to 1 so a request held high through reset is not an edge.
            req_prev_q <= 1'b1;
        end else begin
            state_q    <= state_d;
            sync_q     <= sync_d;
            cnt_q      <= cnt_d;
            core_q     <= core_d;
            port_q     <= port_d;
            done_q     <= done_d;
            ack_q      <= ack_d;
            req_prev_q <= req_prev_d;
        end
    end

    assign soft_rst_ack = ack_q;
    assign core_rst_n   = core_q;
    assign port_rst_n   = port_q;
    assign rst_done     = done_q;

`ifdef RST_SEQ_EVT_CNT_EN
    logic [7:0] evt_cnt_q, evt_cnt_d;

    // Counts on the same edge that raises the ack; holds at 255.
    always_comb begin
        evt_cnt_d = evt_cnt_q;
        if (ack_d && (evt_cnt_q != 8'hFF)) begin
            evt_cnt_d = evt_cnt_q + 8'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            evt_cnt_q <= '0;
        end else begin
            evt_cnt_q <= evt_cnt_d;
        end
    end

    assign rst_evt_cnt = evt_cnt_q;
`endif

endmodule
`default_nettype wire

// File: tb/tb_rst_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : tb_rst_sequencer
// Purpose  : Self-checking bench for rst_sequencer. A reference model keeps
//            the number of edges since the current sequence started and
//            derives every output from release-time arithmetic. Directed
//            scenarios are followed by randomized requests and reset pulses.
// Ports    : none
// Options  : RST_SEQ_EVT_CNT_EN - also checks rst_evt_cnt saturation
// Revision : 1.0 - initial release
// ============================================================================
module tb_rst_sequencer;

    localparam int SS      = 2;
    localparam int STR     = 16;
    localparam int NP      = 4;
    localparam int GAP     = 4;
    localparam int DONE_AT = STR + GAP * NP + 1;

    logic          clk;
    logic          rst_n;
    logic          soft_rst_req;
    logic          soft_rst_ack;
    logic          core_rst_n;
    logic [NP-1:0] port_rst_n;
    logic          rst_done;
`ifdef RST_SEQ_EVT_CNT_EN
    logic [7:0]    rst_evt_cnt;
`endif

    rst_sequencer #(
        .SYNC_STAGES (SS),
        .STRETCH     (STR),
        .NUM_PORTS   (NP),
        .STAGE_GAP   (GAP)
    ) u_dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .soft_rst_req (soft_rst_req),
        .soft_rst_ack (soft_rst_ack),
        .core_rst_n   (core_rst_n),
        .port_rst_n   (port_rst_n),
        .rst_done     (rst_done)
`ifdef RST_SEQ_EVT_CNT_EN
        ,
        .rst_evt_cnt  (rst_evt_cnt)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    // Reference model: k = edges since the sequence origin. A cold start
    // begins at -SS (synchronizer latency); a soft reset sets k = 0.
    int k;
    bit m_prev;
    bit m_ack;
    int m_evt;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        k      = -SS;
        m_prev = 1'b1;
        m_ack  = 1'b0;
        m_evt  = 0;
    endtask

    task automatic check_outputs(input string tag);
        logic [NP-1:0] pe;
        for (int i = 0; i < NP; i++) pe[i] = (k >= STR + GAP * (i + 1));
        chk({tag, ".core"}, 32'(core_rst_n), 32'(k >= STR));
        chk({tag, ".port"}, 32'(port_rst_n), 32'(pe));
        chk({tag, ".done"}, 32'(rst_done), 32'(k >= DONE_AT));
        chk({tag, ".ack"}, 32'(soft_rst_ack), 32'(m_ack));
`ifdef RST_SEQ_EVT_CNT_EN
        chk({tag, ".evt"}, 32'(rst_evt_cnt), 32'(m_evt));
`endif
    endtask

    task automatic step();
        bit run;
        bit rise;
        @(posedge clk);
        if (rst_n) begin
            run    = (k >= DONE_AT);
            rise   = soft_rst_req && !m_prev;
            m_prev = soft_rst_req;
            if (run && rise) begin
                k     = 0;
                m_ack = 1'b1;
                if (m_evt < 255) m_evt++;
            end else begin
                m_ack = 1'b0;
                if (k < DONE_AT) k++;
            end
        end
        #1;
        check_outputs("cyc");
    endtask

    // Assert reset between edges and confirm outputs clear with no clock.
    task automatic apply_reset(input int cycles);
        rst_n = 1'b0;
        model_reset();
        #1;
        check_outputs("arst");
        repeat (cycles) step();
        rst_n = 1'b1;
    endtask

    initial begin
        rst_n        = 1'b0;
        soft_rst_req = 1'b0;
        model_reset();
        #1;
        check_outputs("init");
        repeat (3) step();
        rst_n = 1'b1;

        // Cold release sequence.
        repeat (40) step();

        // Request held high for 10 cycles: one ack only.
        soft_rst_req = 1'b1;
        repeat (10) step();
        soft_rst_req = 1'b0;
        repeat (40) step();

        // Reset pulse in the middle of the port release phase.
        apply_reset(2);
        repeat (25) step();
        apply_reset(2);
        repeat (40) step();

        // Rising request during the stretch phase is ignored.
        apply_reset(1);
        repeat (8) step();
        soft_rst_req = 1'b1;
        step();
        soft_rst_req = 1'b0;
        repeat (40) step();

        // Request high across reset deassertion, then a real edge.
        soft_rst_req = 1'b1;
        apply_reset(2);
        repeat (40) step();
        soft_rst_req = 1'b0;
        step();
        soft_rst_req = 1'b1;
        repeat (40) step();
        soft_rst_req = 1'b0;
        step();

`ifdef RST_SEQ_EVT_CNT_EN
        // Drive the event counter into saturation, then clear it.
        for (int n = 0; n < 260; n++) begin
            soft_rst_req = 1'b1;
            step();
            soft_rst_req = 1'b0;
            repeat (34) step();
        end
        chk("evt_sat", 32'(rst_evt_cnt), 32'd255);
        apply_reset(1);
        chk("evt_clr", 32'(rst_evt_cnt), 32'd0);
        repeat (40) step();
`endif

        // Randomized requests with occasional asynchronous reset pulses.
        for (int c = 0; c < 3000; c++) begin
            int r;
            r = int'($urandom_range(0, 99));
            if (r < 5) begin
                soft_rst_req = ~soft_rst_req;
            end else if (r == 99) begin
                apply_reset(int'($urandom_range(1, 3)));
            end
            step();
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
